// File: rtl/adder_tree_pipe_acc.sv
// Masked lane adder tree, fully registered with valid/ready flow control, followed by a
// per-packet accumulator that emits one sum and beat count per i_last-delimited packet.
module adder_tree_pipe_acc #(
  parameter int INPUTS_NUM  = 32,
  parameter int IDATA_WIDTH = 16,
  parameter int SIGNED      = 1,
  parameter int ACC_GUARD   = 8,
  parameter int CNT_WIDTH   = 16,
  localparam int STAGES_NUM = $clog2(INPUTS_NUM),
  localparam int TREE_WIDTH = IDATA_WIDTH + STAGES_NUM,
  localparam int ACC_WIDTH  = TREE_WIDTH + ACC_GUARD
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_valid,
  output logic                              i_ready,
  input  logic [INPUTS_NUM*IDATA_WIDTH-1:0] i_data,
  input  logic [INPUTS_NUM-1:0]             i_mask,
  input  logic                              i_last,
  output logic                              o_valid,
  input  logic                              o_ready,
  output logic [ACC_WIDTH-1:0]              o_data,
  output logic [CNT_WIDTH-1:0]              o_beats
);

  localparam int LEAVES = 1 << STAGES_NUM;
  localparam int NODES  = 2 * LEAVES - 1;

  logic                  advance;
  logic [TREE_WIDTH-1:0] leaf_ext [LEAVES];
  // Heap-ordered tree: node n sums children 2n+1 and 2n+2, leaves sit at LEAVES-1.., root is 0.
  logic [TREE_WIDTH-1:0] node_reg [NODES];
  logic [STAGES_NUM:0]   valid_reg;
  logic [STAGES_NUM:0]   last_reg;

  logic [ACC_WIDTH-1:0]  sum_ext;
  logic [ACC_WIDTH-1:0]  acc_reg;
  logic [ACC_WIDTH-1:0]  acc_next;
  logic [CNT_WIDTH-1:0]  cnt_reg;
  logic [CNT_WIDTH-1:0]  cnt_next;
  logic                  o_valid_reg;
  logic [ACC_WIDTH-1:0]  o_data_reg;
  logic [CNT_WIDTH-1:0]  o_beats_reg;

  assign advance = !o_valid_reg || o_ready;
  assign i_ready = advance;

  genvar gi;
  generate
    for (gi = 0; gi < LEAVES; gi++) begin : g_leaf
      if (gi < INPUTS_NUM) begin : g_lane
        logic [IDATA_WIDTH-1:0] lane_masked;
        // Select on the mask so undriven data on a disabled lane never reaches the sum.
        assign lane_masked = i_mask[gi] ? i_data[gi*IDATA_WIDTH +: IDATA_WIDTH] : '0;
        if (SIGNED != 0) begin : g_sext
          assign leaf_ext[gi] = {{STAGES_NUM{lane_masked[IDATA_WIDTH-1]}}, lane_masked};
        end else begin : g_zext
          assign leaf_ext[gi] = {{STAGES_NUM{1'b0}}, lane_masked};
        end
      end else begin : g_pad
        assign leaf_ext[gi] = '0;
      end
    end

    if (SIGNED != 0) begin : g_sum_sext
      assign sum_ext = {{ACC_GUARD{node_reg[0][TREE_WIDTH-1]}}, node_reg[0]};
    end else begin : g_sum_zext
      assign sum_ext = {{ACC_GUARD{1'b0}}, node_reg[0]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (advance) begin
      for (int n = 0; n < LEAVES; n++) begin
        node_reg[LEAVES-1+n] <= leaf_ext[n];
      end
      for (int n = 0; n < LEAVES - 1; n++) begin
        node_reg[n] <= node_reg[2*n+1] + node_reg[2*n+2];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= '0;
      last_reg  <= '0;
    end else if (advance) begin
      valid_reg <= {valid_reg[STAGES_NUM-1:0], i_valid};
      last_reg  <= {last_reg[STAGES_NUM-1:0], i_last};
    end
  end

  assign acc_next = acc_reg + sum_ext;
  assign cnt_next = cnt_reg + CNT_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg     <= '0;
      cnt_reg     <= '0;
      o_valid_reg <= 1'b0;
      o_data_reg  <= '0;
      o_beats_reg <= '0;
    end else if (advance) begin
      o_valid_reg <= 1'b0;
      if (valid_reg[STAGES_NUM]) begin
        if (last_reg[STAGES_NUM]) begin
          o_data_reg  <= acc_next;
          o_beats_reg <= cnt_next;
          o_valid_reg <= 1'b1;
          acc_reg     <= '0;
          cnt_reg     <= '0;
        end else begin
          acc_reg <= acc_next;
          cnt_reg <= cnt_next;
        end
      end
    end
  end

  assign o_valid = o_valid_reg;
  assign o_data  = o_data_reg;
  assign o_beats = o_beats_reg;

endmodule
